// File: rtl/button_conditioner_multi.sv
// N-channel push-button front end: 2-FF sync, counter debounce, press/release edges,
// long-press detect. Optional auto-repeat on held buttons, enabled by AUTO_REPEAT_EN.

module btn_channel #(
  parameter int DB_CYCLES     = 500_000,
  parameter int HOLD_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 20_000_000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse
);
  localparam int DBW = $clog2(DB_CYCLES);
  localparam int HCW = $clog2(HOLD_CYCLES);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  if (DB_CYCLES < 2) begin : g_db_chk
    $error("DB_CYCLES must be >= 2");
  end
  if (HOLD_CYCLES <= DB_CYCLES) begin : g_hold_chk
    $error("HOLD_CYCLES must exceed DB_CYCLES");
  end
  if (REPEAT_CYCLES < 2) begin : g_rep_chk
    $error("REPEAT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  logic           s0, s1;
  logic [DBW-1:0] db_cnt;
  logic [HCW-1:0] hold_cnt;
  state_t         state;
  logic           differ, db_done, rise, fall;

  assign differ  = (s1 != level);
  assign db_done = differ && (db_cnt == DB_LAST);
  assign rise    = db_done && s1;
  assign fall    = db_done && !s1;

  // Edge pulses are registered alongside level so they appear with the new value.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      s0            <= 1'b0;
      s1            <= 1'b0;
      level         <= 1'b0;
      db_cnt        <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s0            <= btn;
      s1            <= s0;
      press_pulse   <= rise;
      release_pulse <= fall;
      if (!differ) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level  <= s1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // A debounced fall overrides everything, so it also suppresses a coincident long_press.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (fall) begin
        state    <= IDLE;
        hold_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (rise) begin
            state    <= PRESSED;
            hold_cnt <= '0;
          end
          PRESSED: if (hold_cnt == HOLD_LAST) begin
            state      <= HELD;
            long_press <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
          HELD:    state <= HELD;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RCW = $clog2(REPEAT_CYCLES);
  localparam logic [RCW-1:0] REP_LAST = RCW'(REPEAT_CYCLES - 1);
  logic [RCW-1:0] rep_cnt;

  // rep_cnt starts at 0 on the long_press edge, so the first wrap lands REPEAT_CYCLES later.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      rep_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (fall || state != HELD) begin
        rep_cnt <= '0;
      end else if (rep_cnt == REP_LAST) begin
        rep_cnt      <= '0;
        repeat_pulse <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

module button_conditioner_multi #(
  parameter int N_BTN         = 5,
  parameter int DB_CYCLES     = 500_000,
  parameter int HOLD_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 20_000_000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_press,
  output logic [N_BTN-1:0] repeat_pulse
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    btn_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk_in       (clk_in),
      .rst          (rst),
      .btn          (btn_in[i]),
      .level        (btn_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end
endmodule

// File: tb/tb_button_conditioner_multi.sv
// Bench for button_conditioner_multi: window-based behavioural model checked every cycle,
// plus literal edge-timing expectations per scenario. Honours AUTO_REPEAT_EN.

module tb_button_conditioner_multi;
  localparam int N    = 2;
  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int REP  = 5;
  localparam int HWIN = DB + 2;
`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk_in = 1'b0;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level, press_pulse, release_pulse, long_press, repeat_pulse;

  button_conditioner_multi #(
    .N_BTN(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b want %b", nm, $time, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  // Edge sampler: what the DUT saw at the latest rising edge.
  int           ecnt = 0;
  logic [N-1:0] smp_now = '0;
  logic         rst_at_edge = 1'b0;
  initial forever begin
    @(posedge clk_in);
    ecnt++;
    smp_now     = btn_in;
    rst_at_edge = rst;
  end

  // Model: level flips once the last DB synchronized samples all disagree with it;
  // press-relative age drives long_press and repeat timing.
  logic [N-1:0] hist [HWIN];
  logic [N-1:0] m_lvl;
  bit           m_held [N];
  int           m_age  [N];
  logic [N-1:0] e_pr, e_rl, e_lp, e_rp;
  bit           flip;
  int           m_press_cnt [N], m_press_edge [N];
  int           m_rel_cnt [N], m_rel_edge [N];
  int           m_long_cnt [N], m_long_edge [N];
  int           m_rep_q [$];

  initial begin
    for (int c = 0; c < N; c++) begin
      m_press_cnt[c] = 0; m_press_edge[c] = -1;
      m_rel_cnt[c] = 0;   m_rel_edge[c] = -1;
      m_long_cnt[c] = 0;  m_long_edge[c] = -1;
    end
    forever begin
      @(negedge clk_in);
      e_pr = '0; e_rl = '0; e_lp = '0; e_rp = '0;
      if (!rst || !rst_at_edge) begin
        for (int k = 0; k < HWIN; k++) hist[k] = '0;
        m_lvl = '0;
        for (int c = 0; c < N; c++) begin m_held[c] = 0; m_age[c] = 0; end
      end else begin
        for (int k = HWIN - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = smp_now;
        for (int c = 0; c < N; c++) begin
          flip = 1'b1;
          for (int k = 2; k < HWIN; k++) if (hist[k][c] == m_lvl[c]) flip = 1'b0;
          if (flip) begin
            m_lvl[c] = ~m_lvl[c];
            if (m_lvl[c]) begin
              e_pr[c] = 1'b1; m_held[c] = 1; m_age[c] = 0;
              m_press_cnt[c]++; m_press_edge[c] = ecnt;
            end else begin
              e_rl[c] = 1'b1; m_held[c] = 0;
              m_rel_cnt[c]++; m_rel_edge[c] = ecnt;
            end
          end else if (m_held[c]) begin
            m_age[c]++;
            if (m_age[c] == HOLD) begin
              e_lp[c] = 1'b1; m_long_cnt[c]++; m_long_edge[c] = ecnt;
            end
            if (AUTO && m_age[c] > HOLD && (m_age[c] - HOLD) % REP == 0) begin
              e_rp[c] = 1'b1;
              if (c == 0) m_rep_q.push_back(ecnt);
            end
          end
        end
      end
      chk("btn_level", btn_level, m_lvl);
      chk("press_pulse", press_pulse, e_pr);
      chk("release_pulse", release_pulse, e_rl);
      chk("long_press", long_press, e_lp);
      chk("repeat_pulse", repeat_pulse, e_rp);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  int e0, e1, bp0, bp1, br0, br1, bl0, bl1, brq;

  task automatic snap();
    bp0 = m_press_cnt[0]; bp1 = m_press_cnt[1];
    br0 = m_rel_cnt[0];   br1 = m_rel_cnt[1];
    bl0 = m_long_cnt[0];  bl1 = m_long_cnt[1];
    brq = m_rep_q.size();
  endtask

  initial begin
    rst = 1'b0;
    btn_in = '0;
    tick(3);
    chk("reset_level", btn_level, 2'b00);
    chk("reset_press", press_pulse | release_pulse, 2'b00);
    chk("reset_long_rep", long_press | repeat_pulse, 2'b00);
    rst = 1'b1;
    tick(2);

    // 1: chatter then settle high
    snap();
    for (int i = 0; i < 10; i++) begin
      btn_in[0] = (i % 2 == 0);
      tick(1);
    end
    btn_in[0] = 1'b1;
    e0 = ecnt;
    tick(12);
    chki("t1_press_cnt", m_press_cnt[0] - bp0, 1);
    chki("t1_press_edge", m_press_edge[0], e0 + 6);
    chk("t1_level", btn_level, 2'b01);
    btn_in[0] = 1'b0;
    tick(12);
    chk("t1_level_rel", btn_level, 2'b00);

    // 2: 3-cycle glitch is ignored
    snap();
    btn_in[0] = 1'b1;
    tick(3);
    btn_in[0] = 1'b0;
    tick(12);
    chki("t2_press_cnt", m_press_cnt[0] - bp0, 0);
    chki("t2_rel_cnt", m_rel_cnt[0] - br0, 0);
    chk("t2_level", btn_level, 2'b00);

    // 3/4: long hold, repeats, release
    snap();
    btn_in[0] = 1'b1;
    e0 = ecnt;
    tick(40);
    btn_in[0] = 1'b0;
    e1 = ecnt;
    tick(15);
    chki("t3_press_edge", m_press_edge[0], e0 + 6);
    chki("t3_long_cnt", m_long_cnt[0] - bl0, 1);
    chki("t3_long_edge", m_long_edge[0], e0 + 26);
    chki("t3_rep_cnt", m_rep_q.size() - brq, AUTO ? 3 : 0);
    chki("t3_rep_first", (m_rep_q.size() > brq) ? m_rep_q[brq] : -1, AUTO ? e0 + 31 : -1);
    chki("t4_rel_cnt", m_rel_cnt[0] - br0, 1);
    chki("t4_rel_edge", m_rel_edge[0], e1 + 6);
    chk("t4_level", btn_level, 2'b00);

    // 5: both channels together, release ch1 only
    snap();
    btn_in = 2'b11;
    e0 = ecnt;
    tick(10);
    btn_in = 2'b01;
    e1 = ecnt;
    tick(25);
    chki("t5_press0_edge", m_press_edge[0], e0 + 6);
    chki("t5_press1_edge", m_press_edge[1], e0 + 6);
    chki("t5_rel1_edge", m_rel_edge[1], e1 + 6);
    chki("t5_rel0_cnt", m_rel_cnt[0] - br0, 0);
    chki("t5_long0_edge", m_long_edge[0], e0 + 26);
    chki("t5_long1_cnt", m_long_cnt[1] - bl1, 0);
    chk("t5_level", btn_level, 2'b01);

    // 6: reset mid-HELD, release with button still held
    chk("t6_level_pre", btn_level, 2'b01);
    snap();
    rst = 1'b0;
    #1;
    chk("t6_async_level", btn_level, 2'b00);
    chk("t6_async_pulses", press_pulse | release_pulse | long_press | repeat_pulse, 2'b00);
    tick(3);
    rst = 1'b1;
    e0 = ecnt;
    tick(30);
    chki("t6_press_cnt", m_press_cnt[0] - bp0, 1);
    chki("t6_press_edge", m_press_edge[0], e0 + 6);
    chki("t6_long_edge", m_long_edge[0], e0 + 26);
    chk("t6_level", btn_level, 2'b01);

    btn_in = '0;
    tick(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
